// File: rtl/time_set_ctrl_pkg.sv
// Shared widths, limits, FSM encoding and field-wrap helpers for the
// time-setting front end.
package time_set_ctrl_pkg;

  localparam int HOURS_W = 5;
  localparam int MINS_W  = 6;

  localparam logic [HOURS_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MINS_W-1:0]  MAX_MIN  = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // Wrap is decided by compare so out-of-range captured values just count up.
  function automatic logic [HOURS_W-1:0] next_hour(input logic [HOURS_W-1:0] h);
    return (h == MAX_HOUR) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [MINS_W-1:0] next_min(input logic [MINS_W-1:0] m);
    return (m == MAX_MIN) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce, registered press
// pulse and, when REPEAT_EN is set, hold-to-repeat pulses.
module btn_conditioner #(
  parameter int DEB_CYCLES   = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY1 = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RATE1  = RPT_W'(REPEAT_RATE - 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             acc_q, acc_d;
  logic             acc_prev_q, acc_prev_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             pulse_q, pulse_d;
  logic             press;
  logic             rpt_fire;

  // Next-state: accepted level flips only after DEB_CYCLES consecutive
  // disagreeing samples; repeat timer reloads on press, counts while held.
  always_comb begin
    sync0_d    = btn_raw;
    sync1_d    = sync0_q;
    deb_cnt_d  = deb_cnt_q;
    acc_d      = acc_q;
    acc_prev_d = acc_q;
    rpt_cnt_d  = rpt_cnt_q;
    rpt_fire   = 1'b0;

    if (sync1_q == acc_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      acc_d     = sync1_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    press = acc_q & ~acc_prev_q;

    if (REPEAT_EN) begin
      if (press) begin
        rpt_cnt_d = RPT_DELAY1;
      end else if (acc_q) begin
        if (rpt_cnt_q == '0) begin
          rpt_fire  = 1'b1;
          rpt_cnt_d = RPT_RATE1;
        end else begin
          rpt_cnt_d = rpt_cnt_q - 1'b1;
        end
      end
    end

    pulse_d = press | rpt_fire;
  end

  // Register all conditioner state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_q    <= 1'b0;
      sync1_q    <= 1'b0;
      deb_cnt_q  <= '0;
      acc_q      <= 1'b0;
      acc_prev_q <= 1'b0;
      rpt_cnt_q  <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      deb_cnt_q  <= deb_cnt_d;
      acc_q      <= acc_d;
      acc_prev_q <= acc_prev_d;
      rpt_cnt_q  <= rpt_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting front end: mode/inc buttons drive a RUN/EDIT_H/EDIT_M/COMMIT
// FSM that builds an hour/minute preset and strobes load_en for one cycle.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | counter free-running, preset idle, inc ignored
//   ST_EDIT_H | editing hours, hour digits blink
//   ST_EDIT_M | editing minutes, minute digits blink
//   ST_COMMIT | one-cycle load_en, then back to RUN
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES     = 3,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 2,
  parameter int TIMEOUT_CYCLES = 30,
  parameter int BLINK_HALF     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic [HOURS_W-1:0] cur_hours,
  input  logic [MINS_W-1:0]  cur_minutes,
  output logic [HOURS_W-1:0] set_hours,
  output logic [MINS_W-1:0]  set_minutes,
  output logic               load_en,
  output logic               blink_hours,
  output logic               blink_mins,
  output logic               edit_active
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLINK_HALF - 1);

  logic mode_p;
  logic inc_p;

  btn_conditioner #(
    .DEB_CYCLES  (DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (1'b0)
  ) u_mode (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_mode),
    .pulse  (mode_p)
  );

  btn_conditioner #(
    .DEB_CYCLES  (DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .REPEAT_EN   (1'b1)
  ) u_inc (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_inc),
    .pulse  (inc_p)
  );

  state_e             state_q, state_d;
  logic [HOURS_W-1:0] set_hours_q, set_hours_d;
  logic [MINS_W-1:0]  set_minutes_q, set_minutes_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               phase_q, phase_d;
  logic               load_en_q, load_en_d;
  logic               blink_hours_q, blink_hours_d;
  logic               blink_mins_q, blink_mins_d;
  logic               edit_active_q, edit_active_d;

  // Next-state: mode has priority over inc; timeout only when no press this cycle.
  always_comb begin
    state_d       = state_q;
    set_hours_d   = set_hours_q;
    set_minutes_d = set_minutes_q;
    tmo_d         = tmo_q;
    blk_d         = blk_q;
    phase_d       = phase_q;

    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_d       = ST_EDIT_H;
          set_hours_d   = cur_hours;
          set_minutes_d = cur_minutes;
        end
      end
      ST_EDIT_H: begin
        if (mode_p)              state_d     = ST_EDIT_M;
        else if (inc_p)          set_hours_d = next_hour(set_hours_q);
        else if (tmo_q == '0)    state_d     = ST_RUN;
        else                     tmo_d       = tmo_q - 1'b1;
      end
      ST_EDIT_M: begin
        if (mode_p)              state_d       = ST_COMMIT;
        else if (inc_p)          set_minutes_d = next_min(set_minutes_q);
        else if (tmo_q == '0)    state_d       = ST_RUN;
        else                     tmo_d         = tmo_q - 1'b1;
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if ((state_d != state_q) || mode_p || inc_p) tmo_d = TMO_LOAD;

    if (state_d != state_q) begin
      phase_d = 1'b0;
      blk_d   = BLK_LOAD;
    end else if (blk_q == '0) begin
      phase_d = ~phase_q;
      blk_d   = BLK_LOAD;
    end else begin
      blk_d = blk_q - 1'b1;
    end

    load_en_d     = (state_d == ST_COMMIT);
    edit_active_d = (state_d != ST_RUN);
    blink_hours_d = (state_d == ST_EDIT_H) & phase_d;
    blink_mins_d  = (state_d == ST_EDIT_M) & phase_d;
  end

  // FSM, preset, timer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      set_hours_q   <= '0;
      set_minutes_q <= '0;
      tmo_q         <= '0;
      blk_q         <= '0;
      phase_q       <= 1'b0;
      load_en_q     <= 1'b0;
      blink_hours_q <= 1'b0;
      blink_mins_q  <= 1'b0;
      edit_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_hours_q   <= set_hours_d;
      set_minutes_q <= set_minutes_d;
      tmo_q         <= tmo_d;
      blk_q         <= blk_d;
      phase_q       <= phase_d;
      load_en_q     <= load_en_d;
      blink_hours_q <= blink_hours_d;
      blink_mins_q  <= blink_mins_d;
      edit_active_q <= edit_active_d;
    end
  end

  assign set_hours   = set_hours_q;
  assign set_minutes = set_minutes_q;
  assign load_en     = load_en_q;
  assign blink_hours = blink_hours_q;
  assign blink_mins  = blink_mins_q;
  assign edit_active = edit_active_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with hand-computed expectations.
// Buttons change just after a falling edge; the first rising edge after that
// is the first sample. A press pulse appears 5 edges later and the FSM acts
// on the following edge.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       load_en;
  logic       blink_hours;
  logic       blink_mins;
  logic       edit_active;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int load_bad = 0;
  logic [4:0] load_h = '0;
  logic [5:0] load_m = '0;

  time_set_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .set_hours  (set_hours),
    .set_minutes(set_minutes),
    .load_en    (load_en),
    .blink_hours(blink_hours),
    .blink_mins (blink_mins),
    .edit_active(edit_active)
  );

  always #5 clk = ~clk;

  // Record every load strobe and the preset it carried.
  always @(negedge clk) begin
    if (load_en) begin
      load_cnt++;
      load_h = set_hours;
      load_m = set_minutes;
      if (!edit_active) load_bad++;
    end
  end

  task automatic tap(input bit m, input bit i, input int hold);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (set_hours !== 5'd0) begin bad++; $display("FAIL reset_set_hours got=%0d exp=0", set_hours); end
    total++; if (set_minutes !== 6'd0) begin bad++; $display("FAIL reset_set_minutes got=%0d exp=0", set_minutes); end
    total++; if (load_en !== 1'b0) begin bad++; $display("FAIL reset_load_en got=%b exp=0", load_en); end
    total++; if (blink_hours !== 1'b0) begin bad++; $display("FAIL reset_blink_hours got=%b exp=0", blink_hours); end
    total++; if (blink_mins !== 1'b0) begin bad++; $display("FAIL reset_blink_mins got=%b exp=0", blink_mins); end
    total++; if (edit_active !== 1'b0) begin bad++; $display("FAIL reset_edit_active got=%b exp=0", edit_active); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_commit_sequence;
    int l0;
    l0 = load_cnt;
    cur_hours = 5'd13; cur_minutes = 6'd45;
    tap(1, 0, 4);
    total++; if (edit_active !== 1'b1) begin bad++; $display("FAIL cap_edit_active got=%b exp=1", edit_active); end
    total++; if (set_hours !== 5'd13) begin bad++; $display("FAIL cap_hours got=%0d exp=13", set_hours); end
    total++; if (set_minutes !== 6'd45) begin bad++; $display("FAIL cap_minutes got=%0d exp=45", set_minutes); end
    tap(0, 1, 4);
    tap(0, 1, 4);
    total++; if (set_hours !== 5'd15) begin bad++; $display("FAIL inc_hours got=%0d exp=15", set_hours); end
    tap(1, 0, 4);
    repeat (3) tap(0, 1, 4);
    total++; if (set_minutes !== 6'd48) begin bad++; $display("FAIL inc_minutes got=%0d exp=48", set_minutes); end
    total++; if (set_hours !== 5'd15) begin bad++; $display("FAIL min_edit_hours got=%0d exp=15", set_hours); end
    total++; if (load_cnt !== l0) begin bad++; $display("FAIL early_load got=%0d exp=%0d", load_cnt, l0); end
    tap(1, 0, 4);
    total++; if (load_cnt !== l0 + 1) begin bad++; $display("FAIL commit_load_count got=%0d exp=%0d", load_cnt, l0 + 1); end
    total++; if (load_h !== 5'd15 || load_m !== 6'd48) begin bad++; $display("FAIL commit_value got=%0d:%0d exp=15:48", load_h, load_m); end
    total++; if (edit_active !== 1'b0) begin bad++; $display("FAIL commit_back_to_run got=%b exp=0", edit_active); end
  endtask

  task automatic test_wrap;
    int l0;
    l0 = load_cnt;
    cur_hours = 5'd23; cur_minutes = 6'd59;
    tap(1, 0, 4);
    tap(0, 1, 4);
    total++; if (set_hours !== 5'd0) begin bad++; $display("FAIL wrap_hours got=%0d exp=0", set_hours); end
    tap(1, 0, 4);
    tap(0, 1, 4);
    total++; if (set_minutes !== 6'd0) begin bad++; $display("FAIL wrap_minutes got=%0d exp=0", set_minutes); end
    total++; if (set_hours !== 5'd0) begin bad++; $display("FAIL wrap_no_carry got=%0d exp=0", set_hours); end
    tap(1, 0, 4);
    total++; if (load_cnt !== l0 + 1 || load_h !== 5'd0 || load_m !== 6'd0) begin
      bad++; $display("FAIL wrap_commit got=%0d loads %0d:%0d exp=%0d loads 0:0", load_cnt - l0, load_h, load_m, 1);
    end
  endtask

  task automatic test_blink;
    bit found;
    bit exp_b [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    cur_hours = 5'd1; cur_minutes = 6'd2;
    @(negedge clk); btn_mode = 1'b1;
    repeat (4) @(negedge clk); btn_mode = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (edit_active) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL blink_entry_timeout got=no_edit exp=edit"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (blink_hours !== exp_b[k]) begin bad++; $display("FAIL blink_hours_c%0d got=%b exp=%b", k, blink_hours, exp_b[k]); end
    end
    total++; if (blink_mins !== 1'b0) begin bad++; $display("FAIL blink_mins_in_edit_h got=%b exp=0", blink_mins); end
    repeat (2) tap(1, 0, 4);
  endtask

  task automatic test_debounce;
    cur_hours = 5'd5; cur_minutes = 6'd0;
    tap(1, 0, 4);
    @(negedge clk); btn_inc = 1'b1;
    repeat (2) @(negedge clk); btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (set_hours !== 5'd5) begin bad++; $display("FAIL glitch_rejected got=%0d exp=5", set_hours); end
    @(negedge clk); btn_inc = 1'b1;
    repeat (3) @(negedge clk); btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (set_hours !== 5'd5) begin bad++; $display("FAIL deb_too_early got=%0d exp=5", set_hours); end
    @(negedge clk);
    total++; if (set_hours !== 5'd6) begin bad++; $display("FAIL deb_latency got=%0d exp=6", set_hours); end
    repeat (8) @(negedge clk);
    repeat (2) tap(1, 0, 4);
  endtask

  // Held 14 samples: accepted level stays up through press+12 and drops
  // before press+14, giving repeats at +8, +10, +12.
  task automatic test_auto_repeat;
    cur_hours = 5'd10; cur_minutes = 6'd0;
    tap(1, 0, 4);
    @(negedge clk); btn_inc = 1'b1;
    repeat (7) @(negedge clk);
    total++; if (set_hours !== 5'd11) begin bad++; $display("FAIL rpt_first_press got=%0d exp=11", set_hours); end
    repeat (7) @(negedge clk);
    btn_inc = 1'b0;
    total++; if (set_hours !== 5'd11) begin bad++; $display("FAIL rpt_delay_hold got=%0d exp=11", set_hours); end
    @(negedge clk);
    total++; if (set_hours !== 5'd12) begin bad++; $display("FAIL rpt_first_repeat got=%0d exp=12", set_hours); end
    repeat (10) @(negedge clk);
    total++; if (set_hours !== 5'd14) begin bad++; $display("FAIL rpt_total got=%0d exp=14", set_hours); end
  endtask

  task automatic test_timeout;
    int l0;
    bit left;
    bit found;
    l0 = load_cnt;
    left = 1'b0;
    for (int k = 0; k < 60 && !left; k++) begin
      @(negedge clk);
      if (!edit_active) left = 1'b1;
    end
    total++; if (!left) begin bad++; $display("FAIL tmo_exit_wait got=edit exp=run"); end
    total++; if (set_hours !== 5'd14) begin bad++; $display("FAIL tmo_retained got=%0d exp=14", set_hours); end
    cur_hours = 5'd30; cur_minutes = 6'd10;
    @(negedge clk); btn_mode = 1'b1;
    repeat (4) @(negedge clk); btn_mode = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (edit_active) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL tmo_entry_wait got=no_edit exp=edit"); end
    total++; if (set_hours !== 5'd30) begin bad++; $display("FAIL capture_unclamped got=%0d exp=30", set_hours); end
    repeat (29) @(negedge clk);
    total++; if (edit_active !== 1'b1) begin bad++; $display("FAIL tmo_too_early got=%b exp=1", edit_active); end
    @(negedge clk);
    total++; if (edit_active !== 1'b0) begin bad++; $display("FAIL tmo_exit got=%b exp=0", edit_active); end
    total++; if (load_cnt !== l0) begin bad++; $display("FAIL tmo_no_load got=%0d exp=%0d", load_cnt, l0); end
    total++; if (set_hours !== 5'd30 || set_minutes !== 6'd10) begin
      bad++; $display("FAIL tmo_set_kept got=%0d:%0d exp=30:10", set_hours, set_minutes);
    end
  endtask

  task automatic test_mode_inc_same;
    cur_hours = 5'd7; cur_minutes = 6'd20;
    tap(1, 0, 4);
    tap(1, 1, 4);
    total++; if (set_hours !== 5'd7 || set_minutes !== 6'd20) begin
      bad++; $display("FAIL same_cycle_value got=%0d:%0d exp=7:20", set_hours, set_minutes);
    end
    total++; if (edit_active !== 1'b1) begin bad++; $display("FAIL same_cycle_edit got=%b exp=1", edit_active); end
    tap(0, 1, 4);
    total++; if (set_minutes !== 6'd21 || set_hours !== 5'd7) begin
      bad++; $display("FAIL same_cycle_in_edit_m got=%0d:%0d exp=7:21", set_hours, set_minutes);
    end
  endtask

  task automatic test_reset_mid_edit;
    int l0;
    l0 = load_cnt;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (edit_active !== 1'b0) begin bad++; $display("FAIL rst_mid_edit_active got=%b exp=0", edit_active); end
    total++; if (set_hours !== 5'd0 || set_minutes !== 6'd0) begin
      bad++; $display("FAIL rst_mid_set got=%0d:%0d exp=0:0", set_hours, set_minutes);
    end
    total++; if (load_en !== 1'b0 || blink_hours !== 1'b0 || blink_mins !== 1'b0) begin
      bad++; $display("FAIL rst_mid_flags got=%b%b%b exp=000", load_en, blink_hours, blink_mins);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (edit_active !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=%b exp=0", edit_active); end
    total++; if (load_cnt !== l0) begin bad++; $display("FAIL rst_mid_no_load got=%0d exp=%0d", load_cnt, l0); end
  endtask

  initial begin
    test_reset();
    test_commit_sequence();
    test_wrap();
    test_blink();
    test_debounce();
    test_auto_repeat();
    test_timeout();
    test_mode_inc_same();
    test_reset_mid_edit();
    total++; if (load_bad !== 0) begin bad++; $display("FAIL load_outside_edit got=%0d exp=0", load_bad); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
